// File: rtl/rd_stream_adapter_pkg.sv
// Shared definitions for the FIFO read-side stream adapter.
// Holds the buffer state encodings, the default widths shared with the FIFO
// top level, and a helper that maps a state to its buffered-word count.
package rd_stream_adapter_pkg;

  // Default widths shared with the async FIFO top level
  localparam int unsigned DATASIZE_DEF = 8;
  localparam int unsigned ADDRSIZE_DEF = 4;
  localparam int unsigned CNTSIZE_DEF  = 16;
  localparam int unsigned STATE_W      = 2;

  // Buffer occupancy states; the encoding equals the number of held words
  localparam logic [STATE_W-1:0] ST_EMPTY = 2'd0;
  localparam logic [STATE_W-1:0] ST_ONE   = 2'd1;
  localparam logic [STATE_W-1:0] ST_TWO   = 2'd2;

  // Number of buffered words for a given state (unreachable codes read as 0)
  function automatic logic [1:0] level_of(input logic [STATE_W-1:0] st);
    logic [1:0] lvl;
    lvl = 2'd0;
    case (st)
      ST_ONE:  lvl = 2'd1;
      ST_TWO:  lvl = 2'd2;
      default: lvl = 2'd0;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/rd_stream_adapter.sv
// rd_stream_adapter: read-side consumer of the async FIFO (rclk domain only).
// Converts the FIFO rdata/empty/rinc interface into a registered valid/ready
// stream using a 2-entry head/skid buffer, so m_ready never reaches rinc
// combinationally while still sustaining one word per cycle.
// Ports:
//   rclk        read-domain clock
//   r_rst       synchronous active-high reset
//   fifo_rdata  FIFO read data, valid whenever fifo_empty=0
//   fifo_empty  FIFO empty flag
//   fifo_rinc   pop strobe to the FIFO (combinational)
//   flush       synchronous discard of buffered words
//   m_data      stream data (head entry, registered)
//   m_valid     stream valid (registered)
//   m_ready     downstream ready
//   word_cnt    count of accepted handshakes, wraps silently
//   buf_level   number of buffered words, 0..2
module rd_stream_adapter
  import rd_stream_adapter_pkg::*;
#(
  parameter int unsigned DATASIZE = DATASIZE_DEF,
  parameter int unsigned CNTSIZE  = CNTSIZE_DEF
) (
  input  logic                rclk,
  input  logic                r_rst,
  input  logic [DATASIZE-1:0] fifo_rdata,
  input  logic                fifo_empty,
  output logic                fifo_rinc,
  input  logic                flush,
  output logic [DATASIZE-1:0] m_data,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [CNTSIZE-1:0]  word_cnt,
  output logic [1:0]          buf_level
);

  logic [STATE_W-1:0]  state;
  logic [STATE_W-1:0]  state_nxt;
  logic [DATASIZE-1:0] skid;
  logic                enq;
  logic                deq;
  logic                head_ld;
  logic                head_from_skid;
  logic                skid_ld;

  // Pop only when there is room; TWO is full so no pop is possible there
  assign enq       = !r_rst && !flush && !fifo_empty && (state != ST_TWO);
  assign fifo_rinc = enq;
  assign deq       = m_valid && m_ready;
  assign buf_level = level_of(state);

  // State register
  always_ff @(posedge rclk) begin
    if (r_rst) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and buffer load controls
  always_comb begin
    state_nxt      = state;
    head_ld        = 1'b0;
    head_from_skid = 1'b0;
    skid_ld        = 1'b0;
    if (flush) begin
      state_nxt = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (enq) begin
            state_nxt = ST_ONE;
            head_ld   = 1'b1;
          end
        end
        ST_ONE: begin
          if (enq && deq) begin
            head_ld = 1'b1;
          end else if (enq) begin
            state_nxt = ST_TWO;
            skid_ld   = 1'b1;
          end else if (deq) begin
            state_nxt = ST_EMPTY;
          end
        end
        ST_TWO: begin
          // Skid word is older than anything still in the FIFO
          if (deq) begin
            state_nxt      = ST_ONE;
            head_ld        = 1'b1;
            head_from_skid = 1'b1;
          end
        end
        default: begin
          state_nxt = ST_EMPTY;
        end
      endcase
    end
  end

  // Head/skid data and registered valid
  always_ff @(posedge rclk) begin
    if (r_rst) begin
      m_data  <= '0;
      skid    <= '0;
      m_valid <= 1'b0;
    end else begin
      m_valid <= (state_nxt != ST_EMPTY);
      if (head_ld) begin
        m_data <= head_from_skid ? skid : fifo_rdata;
      end
      if (skid_ld) begin
        skid <= fifo_rdata;
      end
    end
  end

  // Delivered-word counter; a handshake coincident with flush still counts
  always_ff @(posedge rclk) begin
    if (r_rst) begin
      word_cnt <= '0;
    end else if (deq) begin
      word_cnt <= word_cnt + CNTSIZE'(1);
    end
  end

endmodule

// File: tb/tb_rd_stream_adapter.sv
// Self-checking bench for rd_stream_adapter. A queue-based FIFO model feeds
// the DUT; a queue-based buffer model predicts rinc, valid, data, level and
// the handshake counter every cycle.
module tb_rd_stream_adapter;

  localparam int unsigned DW    = 8;
  localparam int unsigned CNT_W = 4;

  logic          rclk = 1'b0;
  logic          r_rst = 1'b1;
  logic [DW-1:0] fifo_rdata = '0;
  logic          fifo_empty = 1'b1;
  logic          fifo_rinc;
  logic          flush = 1'b0;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [CNT_W-1:0] word_cnt;
  logic [1:0]    buf_level;

  rd_stream_adapter #(.DATASIZE(DW), .CNTSIZE(CNT_W)) dut (
    .rclk      (rclk),
    .r_rst     (r_rst),
    .fifo_rdata(fifo_rdata),
    .fifo_empty(fifo_empty),
    .fifo_rinc (fifo_rinc),
    .flush     (flush),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .word_cnt  (word_cnt),
    .buf_level (buf_level)
  );

  always #5 rclk = ~rclk;

  int checks = 0;
  int errors = 0;
  int pops   = 0;
  int cnt    = 0;
  logic [DW-1:0] fq[$];    // words waiting in the FIFO
  logic [DW-1:0] mbuf[$];  // words held by the adapter, oldest first
  logic [DW-1:0] dlog[$];  // words delivered by handshakes
  logic [DW-1:0] sent[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check rinc, advance model, check outputs
  task automatic step(input logic rst, input logic rdy, input logic fl, input logic bub);
    logic exp_rinc;
    logic deq;
    @(negedge rclk);
    r_rst      = rst;
    m_ready    = rdy;
    flush      = fl;
    fifo_empty = (fq.size() == 0) || bub;
    fifo_rdata = (fq.size() != 0) ? fq[0] : 8'h00;
    #1;
    exp_rinc = !rst && !fl && !fifo_empty && (mbuf.size() < 2);
    chk("rinc", 32'(fifo_rinc), 32'(exp_rinc));
    if (fifo_rinc === 1'b1) pops++;
    @(posedge rclk);
    if (rst) begin
      mbuf.delete();
      cnt = 0;
    end else begin
      deq = (mbuf.size() > 0) && rdy;
      if (deq) begin
        dlog.push_back(mbuf[0]);
        cnt = (cnt + 1) % (1 << CNT_W);
      end
      if (fl) begin
        mbuf.delete();
      end else begin
        if (deq) void'(mbuf.pop_front());
        if (exp_rinc) mbuf.push_back(fq.pop_front());
      end
    end
    #1;
    chk("m_valid", 32'(m_valid), 32'(mbuf.size() > 0));
    chk("buf_level", 32'(buf_level), 32'(mbuf.size()));
    chk("word_cnt", 32'(word_cnt), 32'(cnt));
    if (mbuf.size() > 0) chk("m_data", 32'(m_data), 32'(mbuf[0]));
  endtask

  initial begin
    int last;
    // 1. Reset with a non-empty FIFO
    for (int i = 1; i <= 16; i++) fq.push_back(8'(i));
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("rst_m_data", 32'(m_data), 32'h0);
    chk("rst_valid", 32'(m_valid), 32'h0);
    chk("rst_cnt", 32'(word_cnt), 32'h0);

    // 2. Streaming 0x01..0x10 with m_ready held high
    pops = 0;
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("stream_pops", 32'(pops), 32'd16);
    chk("stream_lag", 32'(dlog.size()), 32'd15);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("stream_len", 32'(dlog.size()), 32'd16);
    for (int i = 0; i < 16 && i < dlog.size(); i++)
      chk("stream_data", 32'(dlog[i]), 32'(i + 1));
    chk("stream_cnt", 32'(word_cnt), 32'(16 % (1 << CNT_W)));

    // 3. Backpressure
    dlog.delete();
    for (int i = 0; i < 4; i++) fq.push_back(8'(8'hA0 + i));
    pops = 0;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("bp_pops", 32'(pops), 32'd2);
    chk("bp_level", 32'(buf_level), 32'd2);
    chk("bp_head", 32'(m_data), 32'hA0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("bp_len", 32'(dlog.size()), 32'd4);
    for (int i = 0; i < 4 && i < dlog.size(); i++)
      chk("bp_data", 32'(dlog[i]), 32'(8'hA0 + i));

    // 4. Flush while full, then while one word is held and the FIFO is non-empty
    fq.push_back(8'h55);
    fq.push_back(8'h66);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("fl_level_pre", 32'(buf_level), 32'd2);
    fq.push_back(8'h77);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("fl_valid", 32'(m_valid), 32'h0);
    chk("fl_level", 32'(buf_level), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("fl_next", 32'(m_data), 32'h77);
    fq.push_back(8'h88);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    chk("fl_valid2", 32'(m_valid), 32'h0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0);

    // 5. Counter wrap over 17 handshakes from zero
    step(1'b1, 1'b0, 1'b0, 1'b0);
    dlog.delete();
    for (int i = 0; i < 17; i++) fq.push_back(8'($urandom));
    last = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0);
      if (dlog.size() != last) begin
        last = dlog.size();
        if (last == 15) chk("wrap15", 32'(word_cnt), 32'd15);
        if (last == 16) chk("wrap0", 32'(word_cnt), 32'd0);
        if (last == 17) chk("wrap1", 32'(word_cnt), 32'd1);
      end
    end
    chk("wrap_len", 32'(dlog.size()), 32'd17);

    // 6. Bubbles on fifo_empty with random m_ready
    dlog.delete();
    sent.delete();
    for (int i = 0; i < 40; i++) begin
      sent.push_back(8'($urandom));
      fq.push_back(sent[i]);
    end
    for (int i = 0; i < 400 && dlog.size() < 40; i++)
      step(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'(i % 2));
    chk("bub_len", 32'(dlog.size()), 32'd40);
    for (int i = 0; i < 40 && i < dlog.size(); i++)
      chk("bub_data", 32'(dlog[i]), 32'(sent[i]));

    // 7. Random mix of flush, reset, bubbles and backpressure
    for (int i = 0; i < 200; i++) begin
      if (fq.size() < 3) fq.push_back(8'($urandom));
      step(1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 3) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
